// File: rtl/cross_bar_pkg.sv
// Shared cross bar types: address and data widths and their bus typedefs.
package cross_bar_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/cross_bar_slave_arb_if.sv
// Master-side request/response bundle and slave-side port of one cross bar slave arbiter.
interface cross_bar_slave_arb_if #(
  parameter int unsigned MASTER_N = 4
);
  import cross_bar_pkg::*;

  localparam int unsigned ID_W = $clog2(MASTER_N);

  logic  [MASTER_N-1:0] m_req;
  addr_t [MASTER_N-1:0] m_addr;
  logic  [MASTER_N-1:0] m_cmd;
  data_t [MASTER_N-1:0] m_wdata;
  logic  [MASTER_N-1:0] m_ack;
  data_t [MASTER_N-1:0] m_rdata;
  logic  [MASTER_N-1:0] m_err;

  logic                 slave_req;
  addr_t                slave_addr;
  logic                 slave_cmd;
  data_t                slave_wdata;
  logic                 slave_ack;
  data_t                slave_rdata;

  logic [ID_W-1:0]      grant_id;
  logic                 busy;

  // Arbiter side
  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, slave_ack, slave_rdata,
    output m_ack, m_rdata, m_err, slave_req, slave_addr, slave_cmd, slave_wdata,
    output grant_id, busy
  );

  // Masters plus the slave device, as seen from outside the arbiter
  modport master (
    output m_req, m_addr, m_cmd, m_wdata, slave_ack, slave_rdata,
    input  m_ack, m_rdata, m_err, slave_req, slave_addr, slave_cmd, slave_wdata,
    input  grant_id, busy
  );
endinterface

// File: rtl/cross_bar_slave_arb.sv
// Round-robin, non-preemptive arbiter sharing one slave port among MASTER_N masters.
// Optional grant timeout with error response is enabled by defining CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_slave_arb
  import cross_bar_pkg::*;
#(
  parameter int unsigned MASTER_N = 4
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  areset,
  cross_bar_slave_arb_if.slave  bus
);

  localparam int unsigned ID_W = $clog2(MASTER_N);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] ptr_next;
  logic            scan_found;
  logic            req_g;
  logic            tmo_hit;
  logic            slave_req_c;

  logic  [MASTER_N-1:0] m_ack_c;
  logic  [MASTER_N-1:0] m_err_c;
  data_t [MASTER_N-1:0] m_rdata_c;

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Last permitted GRANT cycle with no ack: abort instead of waiting further
  assign tmo_hit = (state_q == ST_GRANT) && !bus.slave_ack &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign req_g       = bus.m_req[grant_id_q];
  assign slave_req_c = (state_q == ST_GRANT) && req_g && !tmo_hit;
  assign ptr_next    = (grant_id_q == ID_W'(MASTER_N - 1)) ? '0 : grant_id_q + ID_W'(1);

  // First requester at or above ptr, wrapping around
  always_comb begin
    win_id     = ptr_q;
    scan_found = 1'b0;
    for (int unsigned i = 0; i < MASTER_N; i++) begin
      if (!scan_found && bus.m_req[ID_W'((32'(ptr_q) + i) % MASTER_N)]) begin
        scan_found = 1'b1;
        win_id     = ID_W'((32'(ptr_q) + i) % MASTER_N);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_req) begin
          grant_id_d = win_id;
          state_d    = ST_GRANT;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Leave on completion, on requester abort, or on timeout
        if ((bus.slave_ack && slave_req_c) || !req_g || tmo_hit) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next;
        end
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        else if (!bus.slave_ack) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Steering: request fields to the slave, response back to the granted master only
  always_comb begin
    m_ack_c   = '0;
    m_err_c   = '0;
    m_rdata_c = '0;
    bus.slave_addr  = '0;
    bus.slave_cmd   = 1'b0;
    bus.slave_wdata = '0;
    if (state_q == ST_GRANT) begin
      bus.slave_addr  = bus.m_addr[grant_id_q];
      bus.slave_cmd   = bus.m_cmd[grant_id_q];
      bus.slave_wdata = bus.m_wdata[grant_id_q];
      m_ack_c[grant_id_q]   = bus.slave_ack;
      m_rdata_c[grant_id_q] = bus.slave_rdata;
      if (tmo_hit) begin
        m_ack_c[grant_id_q]   = 1'b1;
        m_err_c[grant_id_q]   = 1'b1;
        m_rdata_c[grant_id_q] = '1;
      end
    end
  end

  assign bus.slave_req = slave_req_c;
  assign bus.m_ack     = m_ack_c;
  assign bus.m_err     = m_err_c;
  assign bus.m_rdata   = m_rdata_c;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q == ST_GRANT);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Bench for cross_bar_slave_arb: registered-ack memory slave, table of request batches,
// expected-response queue, plus hand sequences for re-request, abort, reset and timeout.
module tb_cross_bar_slave_arb;
  import cross_bar_pkg::*;

  localparam int unsigned MN = 4;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  logic stuck  = 1'b0;

  always #5 clk = ~clk;

  cross_bar_slave_arb_if #(.MASTER_N(MN)) bus ();

  cross_bar_slave_arb #(.MASTER_N(MN)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  // Behavioural slave: ack registered one cycle after slave_req, single-cycle pulse
  logic        sack;
  logic [31:0] srdata;
  logic [31:0] mem [16] = '{default: 32'h0};

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      sack   <= 1'b0;
      srdata <= 32'h0;
    end else begin
      sack <= 1'b0;
      if (bus.slave_req && !sack && !stuck) begin
        sack <= 1'b1;
        if (bus.slave_cmd) begin
          mem[bus.slave_addr[5:2]] <= bus.slave_wdata;
          srdata <= 32'h0;
        end else begin
          srdata <= mem[bus.slave_addr[5:2]];
        end
      end
    end
  end

  assign bus.slave_ack   = sack;
  assign bus.slave_rdata = srdata;

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic        cmd;
    logic [31:0] abase;
    logic [31:0] dbase;
    int          n;
    int          ids [4];
    logic [31:0] rd  [4];
  } vec_t;

  exp_t exp_q [$];
  vec_t vecs  [8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [31:0] rd);
    exp_t e;
    e.id    = id;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Raises the masked requests; each master drops its request the cycle after its ack
  // unless it is in requeue, in which case it stays up once more.
  task automatic run_batch(input logic [3:0] mask, input logic cmd, input logic [31:0] abase,
                           input logic [31:0] dbase, input logic [3:0] requeue);
    logic [3:0] rq;
    logic [3:0] drop;
    logic       gap;
    logic       oth;
    int         budget;
    exp_t       e;
    rq     = requeue;
    gap    = 1'b0;
    budget = 0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        bus.m_addr[i]  = abase + 32'(4 * i);
        bus.m_wdata[i] = dbase + 32'(i);
        bus.m_cmd[i]   = cmd;
        bus.m_req[i]   = 1'b1;
      end
    end
    while ((exp_q.size() != 0 || gap) && budget < 200) begin
      @(negedge clk);
      budget++;
      drop = 4'b0;
      if (gap) begin
        check("idle_gap", 64'({bus.slave_req, bus.busy}), 64'(0));
        gap = 1'b0;
      end
      if (bus.m_ack != 4'b0) begin
        gap = 1'b1;
        if (exp_q.size() == 0) begin
          check("spurious_ack", 64'(bus.m_ack), 64'(0));
        end else begin
          e   = exp_q.pop_front();
          oth = 1'b0;
          for (int j = 0; j < 4; j++) begin
            if (j != e.id && bus.m_rdata[j] != 32'h0) oth = 1'b1;
          end
          check("ack", 64'({bus.grant_id, bus.m_ack, bus.m_err, bus.m_rdata[2'(e.id)], oth}),
                64'({2'(e.id), 4'(1 << e.id), 4'b0000, e.rdata, 1'b0}));
        end
        drop = bus.m_ack & ~rq;
        rq   = rq & ~bus.m_ack;
      end
      @(posedge clk);
      #1;
      bus.m_req = bus.m_req & ~drop;
    end
    if (exp_q.size() != 0) begin
      check("batch_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic quiet;
    logic early_ok;

    // Expected grant order and read data, worked out from the round-robin pointer
    vecs[0] = '{mask: 4'b0100, cmd: 1'b1, abase: 32'h08, dbase: 32'hA5A5A5A3, n: 1,
                ids: '{2, 0, 0, 0}, rd: '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[1] = '{mask: 4'b0100, cmd: 1'b0, abase: 32'h08, dbase: 32'h0, n: 1,
                ids: '{2, 0, 0, 0}, rd: '{32'hA5A5A5A5, 32'h0, 32'h0, 32'h0}};
    vecs[2] = '{mask: 4'b1000, cmd: 1'b1, abase: 32'h20, dbase: 32'h11111110, n: 1,
                ids: '{3, 0, 0, 0}, rd: '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{mask: 4'b1111, cmd: 1'b1, abase: 32'h00, dbase: 32'hC0DE0000, n: 4,
                ids: '{0, 1, 2, 3}, rd: '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[4] = '{mask: 4'b1111, cmd: 1'b0, abase: 32'h00, dbase: 32'h0, n: 4,
                ids: '{0, 1, 2, 3}, rd: '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003}};
    vecs[5] = '{mask: 4'b1010, cmd: 1'b0, abase: 32'h20, dbase: 32'h0, n: 2,
                ids: '{1, 3, 0, 0}, rd: '{32'h0, 32'h11111113, 32'h0, 32'h0}};
    vecs[6] = '{mask: 4'b0110, cmd: 1'b0, abase: 32'h00, dbase: 32'h0, n: 2,
                ids: '{1, 2, 0, 0}, rd: '{32'hC0DE0001, 32'hC0DE0002, 32'h0, 32'h0}};
    vecs[7] = '{mask: 4'b0011, cmd: 1'b0, abase: 32'h00, dbase: 32'h0, n: 2,
                ids: '{0, 1, 0, 0}, rd: '{32'hC0DE0000, 32'hC0DE0001, 32'h0, 32'h0}};

    // Reset with all masters requesting: outputs must stay quiet
    bus.m_req   = 4'hF;
    bus.m_cmd   = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.m_addr[i]  = 32'h100 + 32'(i);
      bus.m_wdata[i] = 32'hDEAD0000 + 32'(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({bus.slave_req, bus.slave_cmd, bus.busy, bus.grant_id, bus.m_ack, bus.m_err}),
          64'(0));
    check("rst_bus", 64'({bus.slave_addr, bus.slave_wdata}), 64'(0));
    check("rst_rdata", 64'(bus.m_rdata != '0), 64'(0));
    bus.m_req = 4'h0;
    bus.m_cmd = 4'h0;
    @(posedge clk);
    #1;
    areset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].ids[k], vecs[v].rd[k]);
      run_batch(vecs[v].mask, vecs[v].cmd, vecs[v].abase, vecs[v].dbase, 4'b0000);
    end

    // ptr is 2: master 0 alone moves it to 1; then master 1 re-requests while 3 waits
    push(0, 32'hC0DE0000);
    run_batch(4'b0001, 1'b0, 32'h0, 32'h0, 4'b0000);
    push(1, 32'hC0DE0001);
    push(3, 32'hC0DE0003);
    push(1, 32'hC0DE0001);
    run_batch(4'b1010, 1'b0, 32'h0, 32'h0, 4'b0010);

    // Abort: granted master drops its request in the first GRANT cycle
    bus.m_addr[0] = 32'h0;
    bus.m_cmd[0]  = 1'b0;
    bus.m_req[0]  = 1'b1;
    @(posedge clk);
    #1;
    bus.m_req[0] = 1'b0;
    @(negedge clk);
    check("abort_granted", 64'({bus.busy, bus.grant_id, bus.slave_req, bus.m_ack}),
          64'({1'b1, 2'd0, 1'b0, 4'b0000}));
    @(negedge clk);
    check("abort_idle", 64'({bus.busy, bus.m_ack}), 64'(0));
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.m_ack != 4'b0) quiet = 1'b0;
    end
    check("abort_no_ack", 64'(quiet), 64'(1));
    @(posedge clk);
    #1;
    // ptr advanced to 1, so master 1 beats master 0
    push(1, 32'hC0DE0001);
    push(0, 32'hC0DE0000);
    run_batch(4'b0011, 1'b0, 32'h0, 32'h0, 4'b0000);

    // Reset while the slave is acknowledging
    bus.m_addr[2] = 32'h08;
    bus.m_cmd[2]  = 1'b0;
    bus.m_req[2]  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.m_ack[2]) found = 1'b1;
    end
    check("ack_before_reset", 64'(bus.m_ack), 64'(4'b0100));
    bus.m_addr[1] = 32'h04;
    bus.m_addr[3] = 32'h0C;
    bus.m_cmd[1]  = 1'b0;
    bus.m_cmd[3]  = 1'b0;
    bus.m_req[1]  = 1'b1;
    bus.m_req[3]  = 1'b1;
    areset = 1'b1;
    #1;
    check("async_reset", 64'({bus.slave_req, bus.m_ack, bus.busy}), 64'(0));
    @(posedge clk);
    #1;
    areset = 1'b0;
    push(1, 32'hC0DE0001);
    push(2, 32'hC0DE0002);
    push(3, 32'hC0DE0003);
    run_batch(4'b1110, 1'b0, 32'h0, 32'h0, 4'b0000);

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    // Slave never answers: forced error response in the 16th GRANT cycle
    stuck         = 1'b1;
    bus.m_addr[0] = 32'h0;
    bus.m_cmd[0]  = 1'b0;
    bus.m_req[0]  = 1'b1;
    @(posedge clk);
    early_ok = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (bus.m_ack != 4'b0 || !bus.slave_req || !bus.busy) early_ok = 1'b0;
    end
    check("tmo_wait", 64'(early_ok), 64'(1));
    @(negedge clk);
    check("tmo_abort", 64'({bus.slave_req, bus.m_ack, bus.m_err, bus.m_rdata[0]}),
          64'({1'b0, 4'b0001, 4'b0001, 32'hFFFFFFFF}));
    @(posedge clk);
    #1;
    bus.m_req[0] = 1'b0;
    @(negedge clk);
    check("tmo_idle", 64'({bus.busy, bus.m_ack}), 64'(0));
    stuck = 1'b0;
`else
    early_ok = 1'b1;
    check("no_err", 64'({bus.m_err, early_ok}), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cross_bar_slave_arb.md
# cross_bar_slave_arb

Per-slave arbiter of the cross bar. It shares one slave port among MASTER_N master ports using round-robin, non-preemptive arbitration. It holds each grant until the slave acknowledges, and steers the request fields to the slave and the ack/rdata back to the winner. One instance sits in front of each slave (e.g. the behavioural memory slave), between the master-side decode and the slave interface.

## Interface
- MASTER_N, 4, number of requesting master ports (2..16)
- TIMEOUT_CYCLES, 16, cycles spent in GRANT before a forced abort (macro build only; 2..255)
- clk  in  1  clock, all logic on posedge
- areset  in  1  asynchronous, active-high reset
- m_req  in  MASTER_N  per-master request
- m_addr  in  MASTER_N x addr_t  per-master address
- m_cmd  in  MASTER_N  per-master command, 1 = write, 0 = read
- m_wdata  in  MASTER_N x data_t  per-master write data
- m_ack  out  MASTER_N  per-master acknowledge
- m_rdata  out  MASTER_N x data_t  per-master read data
- m_err  out  MASTER_N  per-master timeout error, valid with m_ack
- slave_req  out  1  request to slave
- slave_addr  out  addr_t  address to slave
- slave_cmd  out  1  command to slave
- slave_wdata  out  data_t  write data to slave
- slave_ack  in  1  slave acknowledge
- slave_rdata  in  data_t  slave read data
- grant_id  out  $clog2(MASTER_N)  currently or last granted master
- busy  out  1  state == GRANT

## Operation
- addr_t and data_t come from cross_bar_pkg; ADDR_W and DATA_W likewise.
- Masters hold req, addr, cmd and wdata stable until m_ack. A transfer completes on the cycle where slave_req && slave_ack.
- Two states: IDLE and GRANT.
- IDLE:
  - If any m_req is set, pick the first set bit scanning upward from ptr, wrapping at MASTER_N.
  - Register it into grant_id and go to GRANT.
  - With no request, stay in IDLE.
- GRANT:
  - slave_req = m_req[grant_id] (gated by timeout, see Configuration).
  - slave_addr, slave_cmd and slave_wdata are muxed from grant_id.
  - m_ack[grant_id] = slave_ack and m_rdata[grant_id] = slave_rdata, both combinational pass-through.
- Exit GRANT to IDLE on either:
  - slave_ack && slave_req, or
  - m_req[grant_id] dropped (abort: no ack is generated).
- On exit, ptr <= (grant_id + 1) mod MASTER_N.
- Non-granted masters: m_ack = 0, m_rdata = 0, m_err = 0.
- When not in GRANT: slave_req = 0 and slave_addr, slave_cmd, slave_wdata = 0.
- Simultaneous requests: only one is granted. Losers keep m_req high and are served in round-robin order.
- A request raised during GRANT waits. It is arbitrated in the IDLE cycle that follows.

## Timing
- Reset values:
  - state IDLE, ptr 0, grant_id 0, busy 0
  - slave_req 0, slave_addr/slave_cmd/slave_wdata 0
  - all m_ack, m_err, m_rdata 0
  - timeout counter 0
- Reset asserted mid-transfer: slave_req and m_ack drop asynchronously. No ack is delivered for the in-flight transfer.
- Arbitration latency: m_req sampled at edge N gives slave_req high in cycle N+1.
- With the registered-ack slave: m_ack in cycle N+2, then IDLE at edge N+3. Peak throughput is one transfer per 3 cycles.
- slave_req is always low for at least one cycle between consecutive grants (the IDLE cycle). This is mandatory, because the slave's ack is registered and must re-arm.
- m_ack is high for exactly one cycle per transfer.

## Configuration
- CROSS_BAR_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to GRANT and increments each GRANT cycle without slave_ack.
  - When the counter == TIMEOUT_CYCLES - 1 and there is no slave_ack, that cycle forces slave_req = 0.
  - The same cycle drives m_ack[grant_id] = 1, m_err[grant_id] = 1 and m_rdata[grant_id] = all ones.
  - The arbiter then goes to IDLE and ptr advances.
- CROSS_BAR_ARB_TIMEOUT_EN undefined: no counter, m_err is tied 0, and GRANT waits indefinitely for slave_ack.

## Test plan
- Single master: m_req[2] write addr 0x00000010, data 0xA5A5A5A5, rising at edge 0 -> slave_req in cycle 1, m_ack[2] in cycle 2, then read back 0xA5A5A5A5 with m_err = 0.
- All four masters requesting with ptr = 0 -> grant order 0,1,2,3. slave_req shows a low gap between grants. Each m_ack fires once.
- Master 1 re-requests immediately after its ack while master 3 is waiting -> master 3 is granted next, then master 1.
- Granted master drops m_req in cycle 1 before ack -> no m_ack, IDLE next cycle, ptr = grant_id + 1.
- areset pulsed while in GRANT -> slave_req and m_ack go to 0 immediately. After release the first grant goes to the lowest requesting index.
- Macro build, slave_ack stuck at 0, TIMEOUT_CYCLES = 16 -> m_ack = m_err = 1 and m_rdata = 0xFFFFFFFF in the 16th GRANT cycle, with slave_req low in that cycle.
